// File: rtl/sevseg_capture.sv
// Seven-segment receive side: samples a multiplexed 4-digit display bus,
// decodes each settled digit slot and emits coherent 4-digit frames.
module sevseg_capture #(
  parameter int SETTLE    = 4,
  parameter int TIMEOUT_W = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  input  logic [3:0] an_in,
  output logic [4:0] dig0,
  output logic [4:0] dig1,
  output logic [4:0] dig2,
  output logic [4:0] dig3,
  output logic [3:0] dp_out,
  output logic       frame_valid,
  output logic       locked,
  output logic       err_multi_an,
  output logic       err_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLING,
    S_HELD
  } state_t;

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] C_SAT  = CW'(SETTLE);
  localparam logic [CW-1:0] C_EVAL = CW'(SETTLE - 1);
  localparam logic [TIMEOUT_W-1:0] T_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] T_PRE = T_MAX - 1'b1;
  localparam logic [4:0] C_BLANK = 5'd17;

  // bus layout: {an[3:0], seg[6:0], dp}
  logic [11:0] r_sync1;
  logic [11:0] r_sync2;
  logic [11:0] r_prev;
  logic [CW-1:0] r_cnt;
  state_t r_state;
  state_t w_nxt;

  logic [4:0] r_sh [4];
  logic [3:0] r_sh_dp;
  logic [3:0] r_seen;
  logic [4:0] r_dig [4];
  logic [3:0] r_dp_out;
  logic r_fv;
  logic r_locked;
  logic r_err_multi;
  logic r_err_to;
  logic [TIMEOUT_W-1:0] r_timer;

  logic [3:0] w_an;
  logic [6:0] w_seg;
  logic w_dp;
  logic [3:0] w_anl;
  logic w_chg;
  logic w_stable;
  logic w_idle_an;
  logic w_onehot;
  logic w_eval;
  logic w_cap;
  logic w_multi;
  logic w_to;
  logic w_full;
  logic [1:0] w_idx;
  logic [4:0] w_code;

  function automatic logic [4:0] f_decode(input logic [6:0] s);
    logic [4:0] c;
    unique case (s)
      7'b1000000: c = 5'd0;
      7'b1111001: c = 5'd1;
      7'b0100100: c = 5'd2;
      7'b0110000: c = 5'd3;
      7'b0011001: c = 5'd4;
      7'b0010010: c = 5'd5;
      7'b0000010: c = 5'd6;
      7'b1111000: c = 5'd7;
      7'b0000000: c = 5'd8;
      7'b0010000: c = 5'd9;
      7'b0001000: c = 5'd10;
      7'b0000011: c = 5'd11;
      7'b1000110: c = 5'd12;
      7'b0100001: c = 5'd13;
      7'b0000110: c = 5'd14;
      7'b0001110: c = 5'd15;
      7'b0110111: c = 5'd16;
      7'b1111111: c = 5'd17;
      7'b0111111: c = 5'd18;
      default:    c = 5'd31;
    endcase
    return c;
  endfunction

  assign w_an      = r_sync2[11:8];
  assign w_seg     = r_sync2[7:1];
  assign w_dp      = r_sync2[0];
  assign w_anl     = ~w_an;
  assign w_chg     = (r_sync2 != r_prev);
  assign w_stable  = !w_chg && (r_cnt == C_EVAL);
  assign w_idle_an = &w_an;
  assign w_onehot  = (w_anl != 4'd0) &&
                     ((w_anl & (w_anl - 4'd1)) == 4'd0);
  assign w_code    = f_decode(w_seg);
  assign w_full    = (r_seen == 4'hF);
  assign w_to      = !w_cap && (r_timer == T_PRE);

  // slot index of the single enabled digit
  always_comb begin
    w_idx = 2'd0;
    unique case (w_an)
      4'b1110: w_idx = 2'd0;
      4'b1101: w_idx = 2'd1;
      4'b1011: w_idx = 2'd2;
      4'b0111: w_idx = 2'd3;
      default: w_idx = 2'd0;
    endcase
  end

  // two-flop synchroniser plus one-cycle history for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_prev  <= '1;
    end else begin
      r_sync1 <= {an_in, seg_in, dp_in};
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // stability counter, cleared on any bus change, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_chg) begin
      r_cnt <= '0;
    end else if (r_cnt != C_SAT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!w_idle_an) w_nxt = S_SETTLING;
      end
      S_SETTLING: begin
        if (w_idle_an)     w_nxt = S_IDLE;
        else if (w_stable) w_nxt = S_HELD;
      end
      S_HELD: begin
        if (w_chg) w_nxt = w_idle_an ? S_IDLE : S_SETTLING;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: slot evaluation strobes
  always_comb begin
    w_eval  = (r_state == S_SETTLING) && !w_idle_an && w_stable;
    w_cap   = w_eval && w_onehot;
    w_multi = w_eval && !w_onehot;
  end

  // shadow slots written by each capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_sh[i] <= C_BLANK;
      r_sh_dp <= '0;
    end else if (w_cap) begin
      r_sh[w_idx]    <= w_code;
      r_sh_dp[w_idx] <= ~w_dp;
    end
  end

  // seen mask: cleared on frame completion or timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen <= '0;
    end else if (w_full) begin
      r_seen <= w_cap ? w_anl : 4'd0;
    end else if (w_to) begin
      r_seen <= '0;
    end else if (w_cap) begin
      r_seen <= r_seen | w_anl;
    end
  end

  // frame output registers and frame pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_dig[i] <= C_BLANK;
      r_dp_out <= '0;
      r_fv     <= 1'b0;
    end else begin
      r_fv <= w_full;
      if (w_full) begin
        for (int i = 0; i < 4; i++) r_dig[i] <= r_sh[i];
        r_dp_out <= r_sh_dp;
      end
    end
  end

  // inactivity timer, holds at max until the next capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= '0;
    end else if (w_cap) begin
      r_timer <= '0;
    end else if (r_timer != T_MAX) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // lock status and error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked    <= 1'b0;
      r_err_multi <= 1'b0;
      r_err_to    <= 1'b0;
    end else begin
      r_err_multi <= w_multi;
      r_err_to    <= w_to;
      if (w_to)        r_locked <= 1'b0;
      else if (w_full) r_locked <= 1'b1;
    end
  end

  assign dig0         = r_dig[0];
  assign dig1         = r_dig[1];
  assign dig2         = r_dig[2];
  assign dig3         = r_dig[3];
  assign dp_out       = r_dp_out;
  assign frame_valid  = r_fv;
  assign locked       = r_locked;
  assign err_multi_an = r_err_multi;
  assign err_timeout  = r_err_to;

endmodule

// File: tb/tb_sevseg_capture.sv
// Directed bench for sevseg_capture: scans digit slots on the display bus
// and checks decoded frames, lock, timeout and error pulses.
module tb_sevseg_capture;

  localparam logic [6:0] G_0    = 7'b1000000;
  localparam logic [6:0] G_1    = 7'b1111001;
  localparam logic [6:0] G_2    = 7'b0100100;
  localparam logic [6:0] G_3    = 7'b0110000;
  localparam logic [6:0] G_4    = 7'b0011001;
  localparam logic [6:0] G_5    = 7'b0010010;
  localparam logic [6:0] G_6    = 7'b0000010;
  localparam logic [6:0] G_7    = 7'b1111000;
  localparam logic [6:0] G_8    = 7'b0000000;
  localparam logic [6:0] G_9    = 7'b0010000;
  localparam logic [6:0] G_A    = 7'b0001000;
  localparam logic [6:0] G_B    = 7'b0000011;
  localparam logic [6:0] G_C    = 7'b1000110;
  localparam logic [6:0] G_D    = 7'b0100001;
  localparam logic [6:0] G_E    = 7'b0000110;
  localparam logic [6:0] G_EQ   = 7'b0110111;
  localparam logic [6:0] G_DASH = 7'b0111111;
  localparam logic [6:0] G_BAD  = 7'b1010101;
  localparam logic [6:0] G_BLNK = 7'b1111111;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic       dp_in;
  logic [3:0] an_in;
  logic [4:0] dig0, dig1, dig2, dig3;
  logic [3:0] dp_out;
  logic       frame_valid, locked, err_multi_an, err_timeout;

  int n_vec;
  int n_err;
  int cyc;
  int t0;
  int t_to;
  int n_fv;
  int n_mu;
  int n_to;
  int b_fv, b_mu, b_to;

  sevseg_capture #(
    .SETTLE(4),
    .TIMEOUT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .seg_in(seg_in),
    .dp_in(dp_in),
    .an_in(an_in),
    .dig0(dig0),
    .dig1(dig1),
    .dig2(dig2),
    .dig3(dig3),
    .dp_out(dp_out),
    .frame_valid(frame_valid),
    .locked(locked),
    .err_multi_an(err_multi_an),
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    n_fv = 0;
    n_mu = 0;
    n_to = 0;
    t_to = -1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid)  n_fv = n_fv + 1;
      if (err_multi_an) n_mu = n_mu + 1;
      if (err_timeout) begin
        n_to = n_to + 1;
        t_to = cyc;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic slot(input logic [3:0] an,
                      input logic [6:0] sg,
                      input logic d,
                      input int n);
    an_in  = an;
    seg_in = sg;
    dp_in  = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    slot(4'b1111, G_BLNK, 1'b1, n);
  endtask

  task automatic mark;
    b_fv = n_fv;
    b_mu = n_mu;
    b_to = n_to;
  endtask

  task automatic pulse_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = cyc;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    an_in  = 4'b1111;
    seg_in = G_BLNK;
    dp_in  = 1'b1;
    t0     = 0;
    b_fv   = 0;
    b_mu   = 0;
    b_to   = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dig0", dig0, 17);
    chk("rst_dig1", dig1, 17);
    chk("rst_dig2", dig2, 17);
    chk("rst_dig3", dig3, 17);
    chk("rst_dp", dp_out, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_lock", locked, 0);
    chk("rst_emu", err_multi_an, 0);
    chk("rst_eto", err_timeout, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = cyc;

    // basic frame 1,2,3,A with dp on digit 2
    mark();
    slot(4'b1110, G_1, 1'b1, 16);
    slot(4'b1101, G_2, 1'b1, 16);
    slot(4'b1011, G_3, 1'b0, 16);
    slot(4'b0111, G_A, 1'b1, 16);
    idle(20);
    chk("f1_count", n_fv - b_fv, 1);
    chk("f1_dig0", dig0, 1);
    chk("f1_dig1", dig1, 2);
    chk("f1_dig2", dig2, 3);
    chk("f1_dig3", dig3, 10);
    chk("f1_dp", dp_out, 4'b0100);
    chk("f1_lock", locked, 1);
    chk("f1_errs", (n_mu - b_mu) + (n_to - b_to), 0);

    // slots too short to settle: nothing captured, timeout at 255
    pulse_reset();
    mark();
    for (int r = 0; r < 30; r++) begin
      slot(4'b1110, G_4, 1'b1, 3);
      slot(4'b1101, G_5, 1'b1, 3);
      slot(4'b1011, G_6, 1'b1, 3);
      slot(4'b0111, G_7, 1'b1, 3);
    end
    idle(5);
    chk("sh_fv", n_fv - b_fv, 0);
    chk("sh_to_cnt", n_to - b_to, 1);
    chk("sh_to_cyc", t_to - t0, 255);
    chk("sh_lock", locked, 0);
    chk("sh_dig0", dig0, 17);

    // three slots, a multi-enable burst, then the last slot
    mark();
    slot(4'b1110, G_EQ, 1'b1, 16);
    slot(4'b1101, G_DASH, 1'b1, 16);
    slot(4'b1011, G_BAD, 1'b1, 16);
    slot(4'b1100, G_8, 1'b1, 10);
    idle(10);
    chk("mu_pulse", n_mu - b_mu, 1);
    chk("mu_fv", n_fv - b_fv, 0);
    slot(4'b0111, G_BLNK, 1'b1, 16);
    idle(20);
    chk("g_count", n_fv - b_fv, 1);
    chk("g_dig0", dig0, 16);
    chk("g_dig1", dig1, 18);
    chk("g_dig2", dig2, 31);
    chk("g_dig3", dig3, 17);
    chk("g_dp", dp_out, 0);
    chk("g_lock", locked, 1);

    // loss of scan after lock, then recovery
    mark();
    idle(270);
    chk("lost_to", n_to - b_to, 1);
    chk("lost_lock", locked, 0);
    chk("lost_dig0", dig0, 16);
    chk("lost_dig2", dig2, 31);
    chk("lost_fv", n_fv - b_fv, 0);
    mark();
    slot(4'b1110, G_9, 1'b1, 16);
    slot(4'b1101, G_8, 1'b1, 16);
    slot(4'b1011, G_7, 1'b1, 16);
    slot(4'b0111, G_6, 1'b0, 16);
    idle(20);
    chk("rec_count", n_fv - b_fv, 1);
    chk("rec_lock", locked, 1);
    chk("rec_dig0", dig0, 9);
    chk("rec_dig3", dig3, 6);
    chk("rec_dp", dp_out, 4'b1000);

    // reset mid-frame discards the partial frame
    slot(4'b1110, G_4, 1'b1, 16);
    slot(4'b1101, G_5, 1'b1, 16);
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("mr_dig0", dig0, 17);
    chk("mr_dig3", dig3, 17);
    chk("mr_lock", locked, 0);
    chk("mr_dp", dp_out, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    t0 = cyc;
    mark();
    slot(4'b1011, G_D, 1'b1, 16);
    slot(4'b0111, G_E, 1'b1, 16);
    idle(20);
    chk("mr_part_fv", n_fv - b_fv, 0);
    chk("mr_part_d2", dig2, 17);
    slot(4'b1110, G_B, 1'b1, 16);
    slot(4'b1101, G_C, 1'b1, 16);
    idle(20);
    chk("mr_count", n_fv - b_fv, 1);
    chk("mr_dig0", dig0, 11);
    chk("mr_dig1", dig1, 12);
    chk("mr_dig2", dig2, 13);
    chk("mr_dig3", dig3, 14);
    chk("mr_lock2", locked, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
